// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB transmit arbiter: per-unit result FIFOs, round-robin grant onto CDB lanes
module cdb_arbiter #(
  parameter int N_UNITS   = 5,
  parameter int CDB_LANES = 3,
  parameter int BUF_DEPTH = 2,
  parameter int P_REG_NUM = 64,
  parameter int ROB_DEPTH = 16,
  parameter int PW        = $clog2(P_REG_NUM),
  parameter int RW        = $clog2(ROB_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [N_UNITS-1:0]                unit_valid,
  input  logic [N_UNITS-1:0][PW-1:0]        unit_pd,
  input  logic [N_UNITS-1:0][31:0]          unit_data,
  input  logic [N_UNITS-1:0][RW-1:0]        unit_rob,
  output logic [N_UNITS-1:0]                unit_ready,
  output logic [CDB_LANES-1:0]              cdb_we_array,
  output logic [CDB_LANES-1:0][PW-1:0]      cdb_pd_array,
  output logic [CDB_LANES-1:0][31:0]        cdb_funct_out_array,
  output logic [CDB_LANES-1:0][RW-1:0]      cdb_rob_array
);

  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PW-1:0] r_pd   [N_UNITS][BUF_DEPTH];
  logic [31:0]   r_data [N_UNITS][BUF_DEPTH];
  logic [RW-1:0] r_rob  [N_UNITS][BUF_DEPTH];
  logic [AW-1:0] r_rd_ptr [N_UNITS];
  logic [AW-1:0] r_wr_ptr [N_UNITS];
  logic [CW-1:0] r_count  [N_UNITS];
  logic [UW-1:0] r_rr_ptr;

  logic [N_UNITS-1:0] w_push;
  logic [N_UNITS-1:0] w_grant;
  logic [UW-1:0]      w_last;
  logic               w_any;
  logic [UW:0]        w_sum;
  logic [UW-1:0]      w_idx;
  int                 w_n;

  // Ready looks only at the registered count; a same-cycle pop does not free a slot early.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      unit_ready[i] = rst || (r_count[i] != CW'(BUF_DEPTH));
      w_push[i]     = unit_valid[i] && unit_ready[i] && !flush && !rst;
    end
  end

  // Scan from rr_ptr; granted units fill lanes in scan order, idle lanes stay all-zero.
  always_comb begin
    w_grant             = '0;
    w_last              = r_rr_ptr;
    w_any               = 1'b0;
    w_sum               = '0;
    w_idx               = '0;
    w_n                 = 0;
    cdb_we_array        = '0;
    cdb_pd_array        = '0;
    cdb_funct_out_array = '0;
    cdb_rob_array       = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (UW+1)'(k);
      if (w_sum >= (UW+1)'(N_UNITS)) begin
        w_sum = w_sum - (UW+1)'(N_UNITS);
      end
      w_idx = w_sum[UW-1:0];
      if (!rst && !flush && (r_count[w_idx] != '0) && (w_n < CDB_LANES)) begin
        for (int l = 0; l < CDB_LANES; l++) begin
          if (l == w_n) begin
            cdb_we_array[l]        = 1'b1;
            cdb_pd_array[l]        = r_pd[w_idx][r_rd_ptr[w_idx]];
            cdb_funct_out_array[l] = r_data[w_idx][r_rd_ptr[w_idx]];
            cdb_rob_array[l]       = r_rob[w_idx][r_rd_ptr[w_idx]];
          end
        end
        w_grant[w_idx] = 1'b1;
        w_last         = w_idx;
        w_any          = 1'b1;
        w_n            = w_n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (w_push[i]) begin
        r_pd[i][r_wr_ptr[i]]   <= unit_pd[i];
        r_data[i][r_wr_ptr[i]] <= unit_data[i];
        r_rob[i][r_wr_ptr[i]]  <= unit_rob[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < N_UNITS; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        end
        if (w_grant[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        end
        if (w_push[i] && !w_grant[i]) begin
          r_count[i] <= r_count[i] + CW'(1);
        end else if (!w_push[i] && w_grant[i]) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
      end
      if (w_any) begin
        r_rr_ptr <= (w_last == UW'(N_UNITS - 1)) ? '0 : w_last + UW'(1);
      end
    end
  end

  // A unit presenting a result while not ready has violated the handshake; the result is dropped.
  for (genvar g = 0; g < N_UNITS; g++) begin : g_proto
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst || flush)
      !(unit_valid[g] && !unit_ready[g]));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized scoreboard bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
  localparam int NU = 5;
  localparam int NL = 3;
  localparam int PW = 6;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     flush;
  logic [NU-1:0]            unit_valid;
  logic [NU-1:0][PW-1:0]    unit_pd;
  logic [NU-1:0][31:0]      unit_data;
  logic [NU-1:0][RW-1:0]    unit_rob;
  logic [NU-1:0]            unit_ready;
  logic [NL-1:0]            cdb_we_array;
  logic [NL-1:0][PW-1:0]    cdb_pd_array;
  logic [NL-1:0][31:0]      cdb_funct_out_array;
  logic [NL-1:0][RW-1:0]    cdb_rob_array;

  cdb_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .unit_valid          (unit_valid),
    .unit_pd             (unit_pd),
    .unit_data           (unit_data),
    .unit_rob            (unit_rob),
    .unit_ready          (unit_ready),
    .cdb_we_array        (cdb_we_array),
    .cdb_pd_array        (cdb_pd_array),
    .cdb_funct_out_array (cdb_funct_out_array),
    .cdb_rob_array       (cdb_rob_array)
  );

  typedef struct packed {
    logic [PW-1:0] pd;
    logic [31:0]   data;
    logic [RW-1:0] rob;
  } ent_t;

  // Model: one queue of accepted results per unit plus the round-robin start position.
  ent_t exp_q [NU][$];
  int   rr = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin : mon_cycle
      logic [NU-1:0] exp_ready;
      logic [NU-1:0] granted;
      logic [43:0]   exp_lane [NL];
      logic [43:0]   act_lane;
      int            n;
      int            last;
      int            u;
      @(negedge clk);
      for (int i = 0; i < NU; i++) exp_ready[i] = rst || (exp_q[i].size() < 2);
      chk("unit_ready", 64'(unit_ready), 64'(exp_ready));
      for (int l = 0; l < NL; l++) exp_lane[l] = '0;
      granted = '0;
      n = 0;
      last = 0;
      if (!rst && !flush) begin
        for (int k = 0; k < NU; k++) begin
          u = (rr + k) % NU;
          if (exp_q[u].size() > 0 && n < NL) begin
            exp_lane[n] = {1'b1, exp_q[u][0]};
            granted[u] = 1'b1;
            last = u;
            n++;
          end
        end
      end
      for (int l = 0; l < NL; l++) begin
        act_lane = {cdb_we_array[l], cdb_pd_array[l], cdb_funct_out_array[l], cdb_rob_array[l]};
        chk($sformatf("lane%0d", l), 64'(act_lane), 64'(exp_lane[l]));
      end
      for (int i = 0; i < NU; i++) if (granted[i]) void'(exp_q[i].pop_front());
      if (n > 0) rr = (last + 1) % NU;
    end
  end

  // Offers only what the model says the unit may send, so the DUT never sees a protocol error.
  task automatic offer(input int u, input logic [PW-1:0] pd, input logic [31:0] d, input logic [RW-1:0] r);
    if (exp_q[u].size() < 2) begin
      unit_valid[u] = 1'b1;
      unit_pd[u]    = pd;
      unit_data[u]  = d;
      unit_rob[u]   = r;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < NU; i++) exp_q[i].delete();
      rr = 0;
    end else begin
      for (int i = 0; i < NU; i++)
        if (unit_valid[i]) exp_q[i].push_back('{pd: unit_pd[i], data: unit_data[i], rob: unit_rob[i]});
    end
    #1;
    unit_valid = '0;
    unit_pd    = '0;
    unit_data  = '0;
    unit_rob   = '0;
    flush      = 1'b0;
  endtask

  task automatic offer_rand(input int u);
    offer(u, PW'($urandom), $urandom, RW'($urandom));
  endtask

  initial begin
    int pending;
    int budget;
    rst = 1'b1;
    flush = 1'b0;
    unit_valid = '0;
    unit_pd = '0;
    unit_data = '0;
    unit_rob = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    offer(0, 6'd5, 32'hDEAD, 5'd3);
    step();
    repeat (2) step();

    for (int i = 0; i < NU; i++) offer(i, PW'(i + 1), 32'h100 + 32'(i), RW'(i));
    step();
    repeat (3) step();

    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < 4; i++) offer_rand(i);
      step();
    end
    repeat (4) step();

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) offer_rand(i);
      step();
    end
    flush = 1'b1;
    offer_rand(1);
    step();
    offer(3, 6'd9, 32'hBEEF, 5'd1);
    step();
    repeat (3) step();

    offer(4, 6'd20, 32'h7, 5'd7);
    step();
    offer(4, 6'd21, 32'h8, 5'd8);
    step();
    repeat (3) step();

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NU; i++) offer_rand(i);
      step();
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NU; i++) if ($urandom_range(99) < 60) offer_rand(i);
      if ($urandom_range(99) < 3) flush = 1'b1;
      step();
    end

    budget = 0;
    pending = 0;
    for (int i = 0; i < NU; i++) pending += exp_q[i].size();
    while (pending > 0 && budget < 50) begin
      step();
      budget++;
      pending = 0;
      for (int i = 0; i < NU; i++) pending += exp_q[i].size();
    end
    chk("drain_pending", 64'(pending), 64'd0);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
